// File: rtl/fabric_frac_slice.sv
// fabric_frac_slice: NUM_OUT K-input LUTs, optional full adder on LUT0, NUM_OUT FFs, serial config chain; FABRIC_SCAN_EN adds FF scan shift.
// Latency: LUT/adder paths combinational, FF outputs one fabric_clk edge, a full config load takes CFG_W edges.
// Backpressure: none; outputs are not meaningful while ccff_en is high.
module fabric_frac_slice #(
  parameter int LUT_K   = 4,
  parameter int NUM_OUT = 2
) (
  input  logic               fabric_clk,
  input  logic               fabric_reset,
  input  logic               test_enable,
  input  logic [LUT_K-1:0]   fabric_in,
  input  logic               fabric_reg_in,
  input  logic               fabric_sc_in,
  input  logic               fabric_cin,
  input  logic               fabric_ce,
  input  logic               ccff_en,
  input  logic               ccff_head,
  output logic [NUM_OUT-1:0] fabric_out,
  output logic               fabric_reg_out,
  output logic               fabric_sc_out,
  output logic               fabric_cout,
  output logic               ccff_tail
);

  localparam int TBL_W  = 2 ** LUT_K;
  localparam int CFG_W  = NUM_OUT * (TBL_W + 3) + 1;
  localparam int BASE   = NUM_OUT * TBL_W;

  logic [CFG_W-1:0]   cfg;
  logic [NUM_OUT-1:0] q;
  logic [NUM_OUT-1:0] lut;
  logic [NUM_OUT-1:0] d;
  logic [NUM_OUT-1:0] osel;
  logic [NUM_OUT-1:0] dsel;
  logic [NUM_OUT-1:0] ceu;
  logic [NUM_OUT:0]   reg_chain;
  logic [TBL_W-1:0]   tbl;
  logic [LUT_K:0]     in_ext;
  logic               add_en;
  logic               add_a;
  logic               add_b;
  logic               add_sum;
  logic               add_carry;

  assign osel   = cfg[BASE +: NUM_OUT];
  assign dsel   = cfg[BASE + NUM_OUT +: NUM_OUT];
  assign ceu    = cfg[BASE + 2*NUM_OUT +: NUM_OUT];
  assign add_en = cfg[CFG_W-1];

  // Zero-extend so the adder's second operand reads as 0 when LUT_K is 1.
  assign in_ext    = {1'b0, fabric_in};
  assign add_a     = in_ext[0];
  assign add_b     = in_ext[1];
  assign add_sum   = add_a ^ add_b ^ fabric_cin;
  assign add_carry = (add_a & add_b) | (fabric_cin & (add_a ^ add_b));

  // Chain source for FF i is reg_chain[i]: fabric_reg_in for FF0, old Q[i-1] otherwise.
  assign reg_chain = {q, fabric_reg_in};

  always_comb begin
    lut = '0;
    d   = '0;
    tbl = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      tbl    = cfg[i*TBL_W +: TBL_W];
      lut[i] = tbl[fabric_in];
    end
    if (add_en) begin
      lut[0] = add_sum;
    end
    for (int i = 0; i < NUM_OUT; i++) begin
      d[i] = dsel[i] ? reg_chain[i] : lut[i];
    end
  end

`ifdef FABRIC_SCAN_EN
  logic [NUM_OUT:0] scan_chain;
  assign scan_chain = {q, fabric_sc_in};
`endif

  always_ff @(posedge fabric_clk) begin
    if (fabric_reset) begin
      cfg <= '0;
      q   <= '0;
    end else if (ccff_en) begin
      cfg <= {cfg[CFG_W-2:0], ccff_head};
    end
`ifdef FABRIC_SCAN_EN
    else if (test_enable) begin
      q <= scan_chain[NUM_OUT-1:0];
    end
`endif
    else begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (!ceu[i] || fabric_ce) begin
          q[i] <= d[i];
        end
      end
    end
  end

  assign fabric_out     = (osel & q) | (~osel & lut);
  assign fabric_reg_out = q[NUM_OUT-1];
  assign fabric_cout    = add_en & add_carry;
  assign ccff_tail      = cfg[CFG_W-1];

`ifdef FABRIC_SCAN_EN
  assign fabric_sc_out = q[NUM_OUT-1];
`else
  logic unused_scan;
  assign unused_scan   = ^{test_enable, fabric_sc_in};
  assign fabric_sc_out = 1'b0;
`endif

endmodule
